// File: rtl/run_controller_pkg.sv
// run_controller_pkg
//   Shared constants for the run controller slice: the sequencer state
//   encodings, the width of one program output value, and a helper that
//   tells whether a state counts as "busy" towards the host.
package run_controller_pkg;

    localparam int OUT_W = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    // Busy covers every state in which the controller owns the core.
    function automatic logic state_is_busy(input logic [2:0] st);
        return (st == ST_LOAD) || (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/run_controller_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with occupancy count and synchronous flush.
//   A push into a full FIFO is dropped (reported on 'drop') unless a pop
//   happens in the same cycle, in which case both take effect.
//   Pop while empty is ignored. The head value is held in storage, so it
//   stays stable until it is popped.
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              empty the FIFO (wins over push/pop)
//   push, push_data    write request and value
//   pop                read request (head advances)
//   pop_data           current head value
//   empty              no entries held
//   count              number of entries held (0..DEPTH)
//   drop               this cycle's push was discarded because the FIFO was full
module sync_fifo
    import run_controller_pkg::*;
#(
    parameter int WIDTH = OUT_W,
    parameter int DEPTH = 8
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & ~push_ok & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/run_controller.sv
// run_controller
//   Top-level sequencer for the 3-bit computer core. Streams REG_W serial
//   beats of A/B/C initial values into the execute stage, then enables the
//   pipeline and buffers its 3-bit outputs in a FIFO for the host. A halt
//   from the execute stage drains the FIFO and reports done; a saturated
//   run-cycle counter reports error.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               host controls (abort returns to IDLE from anywhere)
//   in_valid, in_bits, in_ready  serial load beats ([0]=A, [1]=B, [2]=C, MSB first)
//   init_regs, A/B/C_lsb_opcode_*  shift enable and serial bits to the execute stage
//   core_en                    pipeline advance enable
//   core_out_valid, core_reg_out, halt_ex   execute stage results
//   out_valid, out_data, out_ready          FIFO head towards the host
//   busy, done, error, overflow, cycle_count  status
module run_controller
    import run_controller_pkg::*;
#(
    parameter int REG_W      = 48,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_W  = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [2:0]            in_bits,
    output logic                  in_ready,
    output logic                  init_regs,
    output logic                  A_lsb_opcode_0,
    output logic                  B_lsb_opcode_1,
    output logic                  C_lsb_opcode_2,
    output logic                  core_en,
    input  logic                  core_out_valid,
    input  logic [OUT_W-1:0]      core_reg_out,
    input  logic                  halt_ex,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  overflow,
    output logic [TIMEOUT_W-1:0]  cycle_count
);

    localparam int BEAT_W = $clog2(REG_W);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]           state_q, state_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [TIMEOUT_W-1:0] cycle_count_q, cycle_count_d;
    logic                 overflow_q, overflow_d;

    logic                 start_ok;
    logic                 beat;
    logic                 cycle_sat;
    logic                 fifo_room;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic [CNT_W-1:0]     fifo_count;

    // Start is only honoured when the core is not owned by a run; abort
    // masks every handshake so nothing is accepted in the abort cycle.
    assign start_ok = start & ~abort &
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign in_ready = (state_q == ST_LOAD) & ~abort;
    assign beat     = in_ready & in_valid;

    assign init_regs      = beat;
    assign A_lsb_opcode_0 = beat & in_bits[0];
    assign B_lsb_opcode_1 = beat & in_bits[1];
    assign C_lsb_opcode_2 = beat & in_bits[2];

    // One slot is kept free for the result already in flight when the
    // pipeline is stalled. A saturated counter also freezes the core so the
    // run stops after exactly 2**TIMEOUT_W-1 advance cycles.
    assign cycle_sat = &cycle_count_q;
    assign fifo_room = (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
    assign core_en   = (state_q == ST_RUN) & ~abort & fifo_room & ~cycle_sat;

    // Results are captured whenever the core presents one, even while stalled.
    assign fifo_push  = (state_q == ST_RUN) & ~abort & core_out_valid;
    assign fifo_pop   = ~fifo_empty & out_ready & ~abort;
    assign fifo_flush = abort | start_ok;

    assign out_valid   = ~fifo_empty;
    assign busy        = state_is_busy(state_q);
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERROR);
    assign overflow    = overflow_q;
    assign cycle_count = cycle_count_q;

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (core_reg_out),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    // Sequencer: halt wins over timeout, and abort wins over everything.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        cycle_count_d = cycle_count_q;
        overflow_d    = overflow_q | fifo_drop;
        if (abort) begin
            state_d       = ST_IDLE;
            beat_cnt_d    = '0;
            cycle_count_d = '0;
            overflow_d    = 1'b0;
        end else if (start_ok) begin
            state_d       = ST_LOAD;
            beat_cnt_d    = '0;
            cycle_count_d = '0;
            overflow_d    = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (beat) begin
                        if (beat_cnt_q == BEAT_W'(REG_W - 1)) begin
                            state_d    = ST_RUN;
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (core_en) begin
                        cycle_count_d = cycle_count_q + TIMEOUT_W'(1);
                    end
                    if (halt_ex) begin
                        state_d = ST_DRAIN;
                    end else if (cycle_sat) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_d = ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            cycle_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            cycle_count_q <= cycle_count_d;
            overflow_q    <= overflow_d;
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller
//   Directed bench for run_controller. A default-parameter instance covers
//   load, run, drain, backpressure, overflow and abort; a second instance
//   with a 4-bit run counter, sharing the same inputs, covers timeout.
module tb_run_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid, out_ready;
    logic [2:0]  in_bits;
    logic        core_out_valid, halt_ex;
    logic [2:0]  core_reg_out;

    logic        in_ready, init_regs, a_out, b_out, c_out, core_en;
    logic        out_valid, busy, done, error, overflow;
    logic [2:0]  out_data;
    logic [15:0] cycle_count;

    logic        in_ready_t, init_regs_t, a_t, b_t, c_t, core_en_t;
    logic        out_valid_t, busy_t, done_t, error_t, overflow_t;
    logic [2:0]  out_data_t;
    logic [3:0]  cycle_count_t;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    run_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
        .init_regs(init_regs), .A_lsb_opcode_0(a_out), .B_lsb_opcode_1(b_out),
        .C_lsb_opcode_2(c_out), .core_en(core_en),
        .core_out_valid(core_out_valid), .core_reg_out(core_reg_out), .halt_ex(halt_ex),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error), .overflow(overflow),
        .cycle_count(cycle_count)
    );

    run_controller #(.REG_W(48), .FIFO_DEPTH(8), .TIMEOUT_W(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready_t),
        .init_regs(init_regs_t), .A_lsb_opcode_0(a_t), .B_lsb_opcode_1(b_t),
        .C_lsb_opcode_2(c_t), .core_en(core_en_t),
        .core_out_valid(core_out_valid), .core_reg_out(core_reg_out), .halt_ex(halt_ex),
        .out_valid(out_valid_t), .out_data(out_data_t), .out_ready(out_ready),
        .busy(busy_t), .done(done_t), .error(error_t), .overflow(overflow_t),
        .cycle_count(cycle_count_t)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
    endtask

    task automatic do_abort();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        #1;
    endtask

    // Streams 48 beats MSB first, optionally with idle gaps, counting the
    // init_regs pulses seen and any serial bit that differs from the input.
    task automatic load_regs(input logic [47:0] a, input logic [47:0] b,
                             input logic [47:0] c, input bit gaps,
                             output int pulses, output int bit_errs);
        pulses   = 0;
        bit_errs = 0;
        for (int i = 47; i >= 0; i--) begin
            if (gaps && (i % 5 == 0)) begin
                @(negedge clk); in_valid = 1'b0; #1;
                if (init_regs === 1'b1) pulses++;
            end
            @(negedge clk); in_valid = 1'b1; in_bits = {c[i], b[i], a[i]}; #1;
            if (init_regs === 1'b1) begin
                pulses++;
                if ({c_out, b_out, a_out} !== {c[i], b[i], a[i]}) bit_errs++;
            end
        end
        @(negedge clk); in_valid = 1'b0; in_bits = 3'b000; #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bits = 3'b000;
        out_ready = 1'b0; core_out_valid = 1'b0; core_reg_out = 3'b000; halt_ex = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({in_ready, init_regs, core_en, out_valid, busy, done, error, overflow} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000000",
                     {in_ready, init_regs, core_en, out_valid, busy, done, error, overflow});
        end
        checks++;
        if (cycle_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_cycle_count: got %0d expected 0", cycle_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold: got in_ready=%b busy=%b expected 0 0", in_ready, busy);
        end
    endtask

    task automatic test_load_and_run();
        logic [2:0] vals [5];
        int pulses, bit_errs, en_errs, n;
        vals[0] = 3'd4; vals[1] = 3'd6; vals[2] = 3'd3; vals[3] = 3'd5; vals[4] = 3'd4;
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_entry: got in_ready=%b busy=%b expected 1 1", in_ready, busy);
        end
        load_regs(48'd729, 48'd0, 48'd0, 1'b1, pulses, bit_errs);
        checks++;
        if (pulses !== 48) begin
            errors++;
            $display("[TB] FAIL load_pulses: got %0d expected 48", pulses);
        end
        checks++;
        if (bit_errs !== 0) begin
            errors++;
            $display("[TB] FAIL load_bits: got %0d bad bits expected 0", bit_errs);
        end
        checks++;
        if (core_en !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_entry: got core_en=%b in_ready=%b expected 1 0", core_en, in_ready);
        end
        en_errs = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            core_out_valid = 1'b1; core_reg_out = vals[k]; halt_ex = (k == 4); #1;
            if (core_en !== 1'b1) en_errs++;
        end
        @(negedge clk); core_out_valid = 1'b0; halt_ex = 1'b0; out_ready = 1'b1; #1;
        checks++;
        if (en_errs !== 0 || core_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_entry: got en_errs=%0d core_en=%b busy=%b expected 0 0 1",
                     en_errs, core_en, busy);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++;
            if (out_valid !== 1'b1 || out_data !== vals[k]) begin
                errors++;
                $display("[TB] FAIL pop_order[%0d]: got valid=%b data=%0d expected 1 %0d",
                         k, out_valid, out_data, vals[k]);
            end
        end
        n = 0;
        @(negedge clk); #1;
        while (done !== 1'b1 && n < 5) begin
            @(negedge clk); #1; n++;
        end
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_done: got done=%b busy=%b out_valid=%b expected 1 0 0",
                     done, busy, out_valid);
        end
        checks++;
        if (cycle_count !== 16'd6) begin
            errors++;
            $display("[TB] FAIL run_cycle_count: got %0d expected 6", cycle_count);
        end
    endtask

    task automatic test_backpressure();
        int pulses, bit_errs, en_errs;
        pulse_start();
        load_regs(48'd0, 48'd0, 48'd0, 1'b0, pulses, bit_errs);
        en_errs = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); core_out_valid = 1'b1; core_reg_out = 3'(k + 1); #1;
            if (core_en !== 1'b1) en_errs++;
        end
        checks++;
        if (en_errs !== 0) begin
            errors++;
            $display("[TB] FAIL bp_core_en_high: got %0d stalled cycles expected 0", en_errs);
        end
        @(negedge clk); core_out_valid = 1'b0; #1;
        checks++;
        if (core_en !== 1'b0 || overflow !== 1'b0 || out_data !== 3'd1) begin
            errors++;
            $display("[TB] FAIL bp_stall: got core_en=%b overflow=%b data=%0d expected 0 0 1",
                     core_en, overflow, out_data);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        checks++;
        if (out_data !== 3'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_head_stable: got valid=%b data=%0d expected 1 1", out_valid, out_data);
        end
        @(negedge clk); out_ready = 1'b0; #1;
        checks++;
        if (core_en !== 1'b1 || out_data !== 3'd2) begin
            errors++;
            $display("[TB] FAIL bp_resume: got core_en=%b data=%0d expected 1 2", core_en, out_data);
        end
        do_abort();
    endtask

    task automatic test_overflow();
        logic [2:0] exp_vals [8];
        int pulses, bit_errs, n;
        exp_vals[0] = 3'd2; exp_vals[1] = 3'd3; exp_vals[2] = 3'd4; exp_vals[3] = 3'd5;
        exp_vals[4] = 3'd6; exp_vals[5] = 3'd7; exp_vals[6] = 3'd0; exp_vals[7] = 3'd5;
        pulse_start();
        load_regs(48'd0, 48'd0, 48'd0, 1'b0, pulses, bit_errs);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); core_out_valid = 1'b1; core_reg_out = 3'(k + 1); #1;
            if (k == 8) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ovf_at_full: got %b expected 0", overflow);
                end
            end
        end
        @(negedge clk); core_out_valid = 1'b0; #1;
        checks++;
        if (overflow !== 1'b1 || out_data !== 3'd1) begin
            errors++;
            $display("[TB] FAIL ovf_set: got overflow=%b data=%0d expected 1 1", overflow, out_data);
        end
        @(negedge clk); core_out_valid = 1'b1; core_reg_out = 3'd5; out_ready = 1'b1;
        @(negedge clk); core_out_valid = 1'b0; out_ready = 1'b0; halt_ex = 1'b1;
        @(negedge clk); halt_ex = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_start_ignored: got overflow=%b busy=%b in_ready=%b expected 1 1 0",
                     overflow, busy, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_vals[k]) begin
                errors++;
                $display("[TB] FAIL ovf_pop[%0d]: got valid=%b data=%0d expected 1 %0d",
                         k, out_valid, out_data, exp_vals[k]);
            end
        end
        n = 0;
        @(negedge clk); #1;
        while (done !== 1'b1 && n < 5) begin
            @(negedge clk); #1; n++;
        end
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_done: got %b expected 1", done);
        end
        pulse_start();
        checks++;
        if (overflow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got overflow=%b in_ready=%b expected 0 1", overflow, in_ready);
        end
        do_abort();
    endtask

    task automatic test_timeout();
        int pulses, bit_errs, en_cnt, n;
        bit seen;
        pulse_start();
        load_regs(48'd0, 48'd0, 48'd0, 1'b0, pulses, bit_errs);
        en_cnt = (core_en_t === 1'b1) ? 1 : 0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk); core_out_valid = (n < 2); core_reg_out = 3'(n + 3); #1;
            if (error_t === 1'b1) seen = 1'b1;
            else if (core_en_t === 1'b1) en_cnt++;
            n++;
        end
        core_out_valid = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL timeout_error: got error=%b after %0d cycles expected 1", error_t, n);
        end
        checks++;
        if (en_cnt !== 15 || cycle_count_t !== 4'hF) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: got en=%0d count=%0d expected 15 15", en_cnt, cycle_count_t);
        end
        checks++;
        if (out_valid_t !== 1'b1 || out_data_t !== 3'd3) begin
            errors++;
            $display("[TB] FAIL timeout_fifo_kept: got valid=%b data=%0d expected 1 3", out_valid_t, out_data_t);
        end
        pulse_start();
        checks++;
        if (in_ready_t !== 1'b1 || out_valid_t !== 1'b0 || error_t !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_restart: got in_ready=%b out_valid=%b error=%b expected 1 0 0",
                     in_ready_t, out_valid_t, error_t);
        end
        do_abort();
    endtask

    task automatic test_abort();
        int pulses, bit_errs;
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); in_valid = 1'b1; in_bits = 3'b111;
        end
        @(negedge clk); abort = 1'b1; #1;
        checks++;
        if (init_regs !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_gate: got init_regs=%b in_ready=%b expected 0 0", init_regs, in_ready);
        end
        @(negedge clk); abort = 1'b0; in_valid = 1'b0; in_bits = 3'b000; #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got busy=%b in_ready=%b done=%b expected 0 0 0",
                     busy, in_ready, done);
        end
        pulse_start();
        load_regs(48'hFFFF_0000_AAAA, 48'h1234_5678_9ABC, 48'h0F0F_3C3C_5A5A, 1'b1, pulses, bit_errs);
        checks++;
        if (pulses !== 48 || bit_errs !== 0) begin
            errors++;
            $display("[TB] FAIL abort_reload: got pulses=%0d bad_bits=%0d expected 48 0", pulses, bit_errs);
        end
        checks++;
        if (core_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_reload_run: got core_en=%b expected 1", core_en);
        end
        do_abort();
    endtask

    initial begin
        test_reset();
        test_load_and_run();
        test_backpressure();
        test_overflow();
        test_timeout();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
